// File: rtl/minibus_pkg.sv
// Shared Mini-Bus definitions: bus widths, width encodings, master FSM states
// and the alignment rule for CPU-side commands.
package minibus_pkg;

  localparam int MB_ADDR_WIDTH = 32;
  localparam int MB_DATA_WIDTH = 32;

  localparam logic [1:0] MB_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MB_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MB_WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } master_state_t;

  // Width 11 is illegal and is reported through the same error path as misalignment.
  function automatic logic mb_misaligned(input logic [1:0] addr, input logic [1:0] width);
    return (width == 2'b11)
        || ((width == MB_WIDTH_HALF) && addr[0])
        || ((width == MB_WIDTH_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/minibus_load_align.sv
// Selects the addressed byte/half-word from a full bus word and sign- or
// zero-extends it; word accesses pass straight through.
module minibus_load_align
  import minibus_pkg::*;
(
  input  logic [MB_DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]               addr_i,
  input  logic [2:0]               width_i,
  output logic [MB_DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        zext;

  always_comb begin
    byte_v = rdata_i[{addr_i, 3'b000} +: 8];
    half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];
    zext   = width_i[2];
    unique case (width_i[1:0])
      MB_WIDTH_BYTE: data_o = {{24{byte_v[7] & ~zext}}, byte_v};
      MB_WIDTH_HALF: data_o = {{16{half_v[15] & ~zext}}, half_v};
      default:       data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/minibus_master_ctrl.sv
// Single-outstanding Mini-Bus master: latches one CPU load/store, issues it on
// the bus with timeout, and holds the extended response until the CPU takes it.
module minibus_master_ctrl
  import minibus_pkg::*;
#(
  parameter int ADDR_WIDTH     = MB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wen,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [2:0]            cmd_width,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  bus_wen,
  output logic                  bus_ren,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [1:0]            bus_width,
  input  logic                  bus_ack,
  input  logic                  bus_err,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TO_LIM = CW'(TIMEOUT_CYCLES);

  master_state_t         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            width_q, width_d;
  logic                  wen_q, wen_d;
  logic                  bus_wen_q, bus_wen_d;
  logic                  bus_ren_q, bus_ren_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  to_q, to_d;
  logic [DATA_WIDTH-1:0] load_data;

  minibus_load_align u_align (
    .rdata_i (bus_rdata),
    .addr_i  (addr_q[1:0]),
    .width_i (width_q),
    .data_o  (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      width_q   <= '0;
      wen_q     <= 1'b0;
      bus_wen_q <= 1'b0;
      bus_ren_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      width_q   <= width_d;
      wen_q     <= wen_d;
      bus_wen_q <= bus_wen_d;
      bus_ren_q <= bus_ren_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    width_d   = width_q;
    wen_d     = wen_q;
    bus_wen_d = bus_wen_q;
    bus_ren_d = bus_ren_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    to_d      = to_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          width_d = cmd_width;
          wen_d   = cmd_wen;
          rdata_d = '0;
          to_d    = 1'b0;
          if (mb_misaligned(cmd_addr[1:0], cmd_width[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d     = 1'b0;
            cnt_d     = '0;
            bus_wen_d = cmd_wen;
            bus_ren_d = ~cmd_wen;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        if (bus_ack || bus_err) begin
          bus_wen_d = 1'b0;
          bus_ren_d = 1'b0;
          err_d     = bus_err;
          rdata_d   = (bus_err || wen_q) ? '0 : load_data;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO_LIM) begin
            bus_wen_d = 1'b0;
            bus_ren_d = 1'b0;
            err_d     = 1'b1;
            to_d      = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          to_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign bus_wen     = bus_wen_q;
  assign bus_ren     = bus_ren_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_width   = width_q[1:0];

endmodule

// File: tb/tb_minibus_master_ctrl.sv
// Randomized bench for minibus_master_ctrl with a configurable slave and a
// transaction-level reference for latency, bus activity and response contents.
module tb_minibus_master_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wen = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [2:0]  cmd_width = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        bus_wen, bus_ren;
  logic [31:0] bus_addr, bus_wdata;
  logic [1:0]  bus_width;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  // slave behaviour: 0 = ack after s_lat extra cycles, 1 = error, 2 = silent
  int   s_mode = 0;
  int   s_lat  = 1;
  int   s_seen = 0;
  logic force_ack = 1'b0;

  minibus_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wen(cmd_wen),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_width(cmd_width),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_width(bus_width),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_wen || bus_ren) begin
      s_seen  = s_seen + 1;
      bus_ack = (s_mode == 0) && (s_seen > s_lat);
      bus_err = (s_mode == 1) && (s_seen > s_lat);
    end else begin
      s_seen  = 0;
      bus_ack = force_ack;
      bus_err = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] width);
    logic [31:0] v;
    int unsigned sh;
    case (width[1:0])
      2'd0: begin
        sh = 8 * int'(addr[1:0]);
        v  = (word >> sh) & 32'h0000_00FF;
        if (!width[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        sh = 16 * int'(addr[1]);
        v  = (word >> sh) & 32'h0000_FFFF;
        if (!width[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic run_cmd(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] width, input logic [31:0] word,
                         input int mode, input int lat, input int hold);
    logic        mis, exp_err, exp_to;
    logic [31:0] exp_data;
    int          exp_k, exp_bus, k, bus_cyc;
    mis = (width[1:0] == 2'd3) || (width[1:0] == 2'd1 && addr[0])
       || (width[1:0] == 2'd2 && addr[1:0] != 2'd0);
    if (mis) begin
      exp_k = 1; exp_bus = 0;
    end else if (mode == 2) begin
      exp_k = TO + 1; exp_bus = TO;
    end else begin
      exp_k = lat + 2; exp_bus = lat + 1;
    end
    exp_err  = mis || (mode != 0);
    exp_to   = !mis && (mode == 2);
    exp_data = (exp_err || wen) ? 32'h0 : ref_load(word, addr, width);

    @(negedge clk);
    s_mode = mode; s_lat = lat; bus_rdata = word;
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_wen = wen; cmd_addr = addr; cmd_wdata = wdata; cmd_width = width; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1; bus_cyc = 0;
    while (!rsp_valid && k < 40) begin
      if (bus_wen || bus_ren) begin
        bus_cyc++;
        check_eq("bus_wen", bus_wen, wen);
        check_eq("bus_ren", bus_ren, !wen);
        check_eq("bus_addr", bus_addr, addr);
        check_eq("bus_width", bus_width, width[1:0]);
        if (wen) check_eq("bus_wdata", bus_wdata, wdata);
      end
      @(negedge clk);
      k++;
    end
    check_eq("rsp_latency", k, exp_k);
    check_eq("bus_cycles", bus_cyc, exp_bus);
    check_eq("rsp_err", rsp_err, exp_err);
    check_eq("rsp_timeout", rsp_timeout, exp_to);
    check_eq("rsp_rdata", rsp_rdata, exp_data);
    check_eq("bus_idle_resp", bus_wen | bus_ren, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_cmd_ready", cmd_ready, 0);
      check_eq("hold_rdata", rsp_rdata, exp_data);
      check_eq("hold_err", rsp_err, exp_err);
      check_eq("hold_timeout", rsp_timeout, exp_to);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_done", rsp_valid, 0);
    check_eq("cmd_ready_back", cmd_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_err", {rsp_err, rsp_timeout}, 0);
    check_eq("rst_bus_en", {bus_wen, bus_ren}, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    rst = 1'b0;

    run_cmd(1'b1, 32'h8, 32'hDEAD_BEEF, 3'b010, 32'h0, 0, 1, 0);
    run_cmd(1'b0, 32'h3, 32'h0, 3'b000, 32'h80FF_1234, 0, 1, 0);
    run_cmd(1'b0, 32'h3, 32'h0, 3'b100, 32'h80FF_1234, 0, 1, 0);
    run_cmd(1'b0, 32'h1, 32'h0, 3'b001, 32'h1234_5678, 0, 1, 0);
    run_cmd(1'b0, 32'h4, 32'h0, 3'b010, 32'hCAFE_F00D, 2, 0, 0);

    // late ack while idle must not create a response
    @(negedge clk);
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("late_ack_valid", rsp_valid, 0);
      check_eq("late_ack_ready", cmd_ready, 1);
    end
    force_ack = 1'b0;

    run_cmd(1'b0, 32'h6, 32'h0, 3'b001, 32'h9ABC_7654, 0, 2, 5);

    // reset in the middle of a request
    @(negedge clk);
    s_mode = 2;
    cmd_wen = 1'b0; cmd_addr = 32'h10; cmd_width = 3'b010; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_req_ren", bus_ren, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_drop_ren", bus_ren, 0);
    check_eq("rst_drop_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", cmd_ready, 1);
    check_eq("post_rst_ren", bus_ren, 0);

    for (int n = 0; n < 40; n++) begin
      logic        wen;
      logic [31:0] addr;
      logic [2:0]  width;
      int          r, mode;
      wen   = 1'($urandom_range(0, 1));
      width = 3'($urandom_range(0, 7));
      addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (width[1:0] == 2'd1) addr[0] = 1'b0;
        if (width[1:0] == 2'd2) addr[1:0] = 2'b00;
      end
      r    = $urandom_range(0, 9);
      mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      run_cmd(wen, addr, $urandom, width, $urandom, mode, $urandom_range(0, 3),
              $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
